// File: rtl/inm_gen_pipe.sv
// rtl/inm_gen_pipe.sv - registered RISC-V immediate generator with two-entry skid buffer
//
// Purpose: decodes the instruction format of an accepted inst/pc beat into an
// XLEN-bit immediate, format code, illegal flag and PC-relative target, and
// buffers up to two results so producer and consumer can stall independently.
//
// Ports:
//   CLK, RST_n        clock, synchronous active-low reset
//   flush             drops all buffered results and the beat offered this cycle
//   in_valid/in_ready inst/pc input handshake (in_ready is registered)
//   inst, pc          instruction word and its address
//   out_valid/out_ready result handshake
//   inm, fmt, illegal, target  decoded result (from the main register)
//   ill_cnt           saturating count of accepted illegal beats
module inm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          inst,
  input  logic [XLEN-1:0]      pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      inm,
  output logic [2:0]           fmt,
  output logic                 illegal,
  output logic [XLEN-1:0]      target,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] inm;
    logic [2:0]      fmt;
    logic            ill;
    logic [XLEN-1:0] tgt;
  } res_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  res_t                  main_q, main_d;
  res_t                  skid_q, skid_d;
  logic                  in_ready_q, in_ready_d;
  logic [ILL_CNT_W-1:0]  ill_cnt_q, ill_cnt_d;

  res_t dec;
  logic use_pc;
  logic in_fire;
  logic out_fire;

  // Combinational decode of the offered beat. Every legal opcode ends in 2'b11,
  // so matching the full 7-bit opcode also rejects inst[1:0] != 2'b11.
  always_comb begin
    dec     = '0;
    dec.fmt = FMT_ILL;
    use_pc  = 1'b0;
    case (inst[6:0])
      7'b0000011, 7'b0001111, 7'b1100111: begin
        dec.fmt = FMT_I;
        dec.inm = XLEN'($signed(inst[31:20]));
      end
      7'b0010011: begin
        dec.fmt = FMT_I;
        // funct3 001/101 are the shifts: zero-extended shamt, funct7 excluded
        if (inst[13:12] == 2'b01) begin
          if (XLEN == 64) dec.inm = XLEN'(inst[25:20]);
          else            dec.inm = XLEN'(inst[24:20]);
        end else begin
          dec.inm = XLEN'($signed(inst[31:20]));
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.inm = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.inm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        use_pc  = 1'b1;
      end
      7'b0110111: begin
        dec.fmt = FMT_U;
        dec.inm = XLEN'($signed({inst[31:12], 12'b0}));
      end
      7'b0010111: begin
        dec.fmt = FMT_U;
        dec.inm = XLEN'($signed({inst[31:12], 12'b0}));
        use_pc  = 1'b1;
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.inm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        use_pc  = 1'b1;
      end
      7'b1110011: begin
        if (inst[14]) begin
          dec.fmt = FMT_Z;
          dec.inm = XLEN'(inst[19:15]);
        end else begin
          dec.fmt = FMT_I;
          dec.inm = XLEN'($signed(inst[31:20]));
        end
      end
      7'b0110011: begin
        dec.fmt = FMT_R;
      end
      default: begin
        dec.fmt = FMT_ILL;
      end
    endcase
    dec.ill = (dec.fmt == FMT_ILL);
    dec.tgt = use_pc ? (pc + dec.inm) : '0;
  end

  // Skid-buffer control. A beat offered during flush never fires.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    ill_cnt_d = ill_cnt_q;
    in_fire   = in_valid && in_ready_q && !flush;
    out_fire  = (state_q != ST_EMPTY) && out_ready;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = dec;
        end else if (in_fire) begin
          skid_d  = dec;
          state_d = ST_TWO;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (flush) state_d = ST_EMPTY;

    if (in_fire && dec.ill && (ill_cnt_q != '1)) begin
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end

    // Registered from the next state so in_ready never depends on out_ready.
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      ill_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  // in_ready is held low for as long as reset is asserted.
  assign in_ready  = in_ready_q && RST_n;
  assign out_valid = (state_q != ST_EMPTY);
  assign inm       = main_q.inm;
  assign fmt       = main_q.fmt;
  assign illegal   = main_q.ill;
  assign target    = main_q.tgt;
  assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_inm_gen_pipe.sv
// tb/tb_inm_gen_pipe.sv - self-checking bench for inm_gen_pipe
module tb_inm_gen_pipe;

  logic        CLK;
  logic        RST_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inm;
  logic [2:0]  fmt;
  logic        illegal;
  logic [31:0] target;
  logic [7:0]  ill_cnt;

  logic        in_valid64;
  logic        in_ready64;
  logic [31:0] inst64;
  logic [63:0] pc64;
  logic        out_valid64;
  logic [63:0] inm64;
  logic [2:0]  fmt64;
  logic        illegal64;
  logic [63:0] target64;
  logic [1:0]  ill_cnt64;

  inm_gen_pipe #(.XLEN(32), .ILL_CNT_W(8)) dut (
    .CLK(CLK), .RST_n(RST_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .inm(inm), .fmt(fmt), .illegal(illegal), .target(target), .ill_cnt(ill_cnt)
  );

  inm_gen_pipe #(.XLEN(64), .ILL_CNT_W(2)) dut64 (
    .CLK(CLK), .RST_n(RST_n), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .inst(inst64), .pc(pc64),
    .out_valid(out_valid64), .out_ready(1'b1),
    .inm(inm64), .fmt(fmt64), .illegal(illegal64), .target(target64), .ill_cnt(ill_cnt64)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit [63:0] inm;
    int        fmt;
    bit        ill;
    bit [63:0] tgt;
  } ref_t;

  typedef struct {
    bit [31:0] inst;
    bit [31:0] pc;
    bit [31:0] inm;
    bit [2:0]  fmt;
    bit        ill;
    bit [31:0] tgt;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  ref_t mq[$];
  int   mcnt = 0;
  bit   last_rst = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit [63:0] fld(input bit [31:0] i, input int hi, input int lo);
    bit [63:0] w;
    w = {32'b0, i};
    return (w >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  // Reference decode built from field values with signed integer arithmetic.
  function automatic ref_t ref_dec(input bit [31:0] i, input bit [63:0] p, input int xl);
    ref_t      r;
    longint    v;
    int        f;
    bit        rel;
    longint    sg;
    bit [63:0] m;
    bit [63:0] f3;
    v   = 0;
    f   = 7;
    rel = 1'b0;
    sg  = i[31] ? 1 : 0;
    f3  = fld(i, 14, 12);
    m   = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (fld(i, 1, 0) == 3) begin
      case (fld(i, 6, 0))
        64'h03, 64'h0F, 64'h67: begin f = 1; v = longint'(fld(i, 31, 20)) - sg * 4096; end
        64'h13: begin
          f = 1;
          if (f3 == 1 || f3 == 5) v = longint'(fld(i, (xl == 64) ? 25 : 24, 20));
          else v = longint'(fld(i, 31, 20)) - sg * 4096;
        end
        64'h23: begin f = 2; v = longint'(fld(i, 31, 25)) * 32 + longint'(fld(i, 11, 7)) - sg * 4096; end
        64'h63: begin
          f = 3; rel = 1'b1;
          v = longint'(fld(i, 7, 7)) * 2048 + longint'(fld(i, 30, 25)) * 32
            + longint'(fld(i, 11, 8)) * 2 - sg * 4096;
        end
        64'h37: begin f = 4; v = longint'(fld(i, 31, 12)) * 4096 - sg * 64'h1_0000_0000; end
        64'h17: begin f = 4; rel = 1'b1; v = longint'(fld(i, 31, 12)) * 4096 - sg * 64'h1_0000_0000; end
        64'h6F: begin
          f = 5; rel = 1'b1;
          v = longint'(fld(i, 19, 12)) * 4096 + longint'(fld(i, 20, 20)) * 2048
            + longint'(fld(i, 30, 21)) * 2 - sg * 1048576;
        end
        64'h73: begin
          if (f3 >= 4) begin f = 6; v = longint'(fld(i, 19, 15)); end
          else begin f = 1; v = longint'(fld(i, 31, 20)) - sg * 4096; end
        end
        64'h33: begin f = 0; v = 0; end
        default: begin f = 7; v = 0; end
      endcase
    end
    r.fmt = f;
    r.ill = (f == 7);
    r.inm = 64'(v) & m;
    r.tgt = rel ? ((p + 64'(v)) & m) : 64'd0;
    return r;
  endfunction

  function automatic bit [31:0] rand_inst();
    bit [6:0]  ops[12];
    bit [31:0] i;
    ops = '{7'h03, 7'h0F, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h00};
    i = $urandom;
    ops[11] = i[6:0] ^ 7'h2A;
    i[6:0] = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 9) == 0) i[1:0] = 2'($urandom_range(0, 2));
    return i;
  endfunction

  task automatic check_main();
    if (!RST_n) chk("in_ready_rst", 64'(in_ready), 64'd0);
    else        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("ill_cnt", 64'(ill_cnt), 64'(mcnt));
    if (mq.size() > 0) begin
      chk("inm", 64'(inm), mq[0].inm);
      chk("fmt", 64'(fmt), 64'(mq[0].fmt));
      chk("illegal", 64'(illegal), 64'(mq[0].ill));
      chk("target", 64'(target), mq[0].tgt);
    end
    if (last_rst) begin
      chk("rst_inm", 64'(inm), 64'd0);
      chk("rst_fmt", 64'(fmt), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_target", 64'(target), 64'd0);
    end
  endtask

  // One clock of the main DUT: called at a negedge with inputs already driven.
  task automatic tick();
    bit   inf;
    bit   outf;
    ref_t r;
    inf  = in_valid && in_ready;
    outf = out_valid && out_ready;
    r    = ref_dec(inst, {32'b0, pc}, 32);
    @(posedge CLK);
    last_rst = !RST_n;
    if (!RST_n) begin
      mq.delete();
      mcnt = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) begin
        mq.push_back(r);
        if (r.ill && mcnt < 255) mcnt++;
      end
    end
    @(negedge CLK);
    check_main();
  endtask

  task automatic beat64(input string nm, input bit [31:0] i, input bit [63:0] p, input ref_t e);
    inst64 = i;
    pc64 = p;
    in_valid64 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid64 = 1'b0;
    chk({nm, "_valid"}, 64'(out_valid64), 64'd1);
    chk({nm, "_inm"}, inm64, e.inm);
    chk({nm, "_fmt"}, 64'(fmt64), 64'(e.fmt));
    chk({nm, "_illegal"}, 64'(illegal64), 64'(e.ill));
    chk({nm, "_target"}, target64, e.tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    vec_t      tbl[12];
    int        obs[$];
    bit        acc;
    logic [7:0] saved;
    ref_t      e;

    tbl[0]  = '{32'hFFF00093, 32'h0000_0000, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h0000_0000};
    tbl[1]  = '{32'hFE000EE3, 32'h0000_0100, 32'hFFFFFFFC, 3'd3, 1'b0, 32'h0000_00FC};
    tbl[2]  = '{32'h001000EF, 32'h0000_1000, 32'h0000_0800, 3'd5, 1'b0, 32'h0000_1800};
    tbl[3]  = '{32'h4030D093, 32'h0000_0000, 32'h0000_0003, 3'd1, 1'b0, 32'h0000_0000};
    tbl[4]  = '{32'h300FD073, 32'h0000_0000, 32'h0000_001F, 3'd6, 1'b0, 32'h0000_0000};
    tbl[5]  = '{32'h00112623, 32'h0000_0040, 32'h0000_000C, 3'd2, 1'b0, 32'h0000_0000};
    tbl[6]  = '{32'hFFFFF097, 32'h0000_0010, 32'hFFFFF000, 3'd4, 1'b0, 32'hFFFFF010};
    tbl[7]  = '{32'h002081B3, 32'h0000_0020, 32'h0000_0000, 3'd0, 1'b0, 32'h0000_0000};
    tbl[8]  = '{32'hFE000EE3, 32'h0000_0000, 32'hFFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFC};
    tbl[9]  = '{32'h00000000, 32'h0000_0100, 32'h0000_0000, 3'd7, 1'b1, 32'h0000_0000};
    tbl[10] = '{32'h00000000, 32'h0000_0104, 32'h0000_0000, 3'd7, 1'b1, 32'h0000_0000};
    tbl[11] = '{32'h00000012, 32'h0000_0108, 32'h0000_0000, 3'd7, 1'b1, 32'h0000_0000};

    RST_n = 1'b0; flush = 1'b0; in_valid = 1'b0; inst = '0; pc = '0; out_ready = 1'b0;
    in_valid64 = 1'b0; inst64 = '0; pc64 = '0;
    @(negedge CLK);
    tick();
    tick();
    RST_n = 1'b1;
    tick();
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Table vectors, one beat per cycle with the consumer always ready.
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1; inst = tbl[k].inst; pc = tbl[k].pc; out_ready = 1'b1;
      tick();
      chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d_inm", k), 64'(inm), 64'(tbl[k].inm));
      chk($sformatf("tbl%0d_fmt", k), 64'(fmt), 64'(tbl[k].fmt));
      chk($sformatf("tbl%0d_illegal", k), 64'(illegal), 64'(tbl[k].ill));
      chk($sformatf("tbl%0d_target", k), 64'(target), 64'(tbl[k].tgt));
    end
    chk("tbl_ill_cnt", 64'(ill_cnt), 64'd3);
    in_valid = 1'b0;
    tick();

    // Backpressure: A and B buffered, C held by the source until space frees.
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'h00100093; pc = 32'h200;
    tick();
    inst = 32'h00200093;
    tick();
    chk("abc_in_ready_two", 64'(in_ready), 64'd0);
    inst = 32'h00300093;
    tick();
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid && out_ready) obs.push_back(int'(inm));
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("abc_count", 64'(obs.size()), 64'd3);
    for (int c = 0; c < obs.size() && c < 3; c++) chk($sformatf("abc_order%0d", c), 64'(obs[c]), 64'(c + 1));

    // Flush while full with an illegal beat offered in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'h00500093;
    tick();
    inst = 32'h00600093;
    tick();
    saved = ill_cnt;
    flush = 1'b1; inst = 32'h00000000;
    tick();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_ill_cnt", 64'(ill_cnt), 64'(saved));
    flush = 1'b0; in_valid = 1'b0;
    tick();

    // Randomised traffic against the queue model.
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      inst      = rand_inst();
      pc        = $urandom;
      tick();
    end
    flush = 1'b0;

    // Reset in the middle of a stream discards buffered beats.
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'h00000000;
    tick();
    inst = 32'h00700093;
    tick();
    RST_n = 1'b0;
    tick();
    chk("midrst_ill_cnt", 64'(ill_cnt), 64'd0);
    RST_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("midrst_in_ready_after", 64'(in_ready), 64'd1);

    // XLEN=64 instance with a 2-bit counter.
    e = '{64'hFFFF_FFFF_8000_0000, 4, 1'b0, 64'd0};
    beat64("lui64", 32'h800000B7, 64'h0, e);
    e = '{64'd33, 1, 1'b0, 64'd0};
    beat64("slli64", 32'h02101093, 64'h0, e);
    for (int k = 0; k < 5; k++) begin
      e = '{64'd0, 7, 1'b1, 64'd0};
      beat64($sformatf("ill64_%0d", k), 32'h00000000, 64'h0, e);
      chk($sformatf("ill64_cnt%0d", k), 64'(ill_cnt64), 64'((k + 1 > 3) ? 3 : k + 1));
    end
    for (int k = 0; k < 20; k++) begin
      bit [31:0] ri;
      bit [63:0] rp;
      ri = rand_inst();
      rp = {$urandom, $urandom};
      e = ref_dec(ri, rp, 64);
      beat64($sformatf("rnd64_%0d", k), ri, rp, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inm_gen_pipe.md
Name: inm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It accepts an instruction and its PC over a valid/ready handshake and decodes the instruction format. It produces the XLEN-bit immediate, a format code, an illegal flag and the PC-relative target. It buffers up to two results in a skid buffer so fetch and execute can stall independently, and it supports flush and a saturating illegal-instruction counter.

Parameters:
XLEN, 32, datapath width for immediate, PC and target; legal values 32 or 64.
ILL_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
CLK  input  1  clock, all state updates on rising edge.
RST_n  input  1  synchronous active-low reset.
flush  input  1  synchronous pipeline flush.
in_valid  input  1  inst/pc beat valid.
in_ready  output  1  block can accept a beat.
inst  input  32  instruction word.
pc  input  XLEN  address of inst.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
inm  output  XLEN  sign-/zero-extended immediate.
fmt  output  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm), 7=ILLEGAL.
illegal  output  1  unknown opcode or inst[1:0]!=2'b11.
target  output  XLEN  pc+inm for B, J and AUIPC; 0 otherwise.
ill_cnt  output  ILL_CNT_W  count of accepted illegal beats, saturating.

Behaviour:
- Decode is combinational on the input beat and captured on accept. An input fire is in_valid&&in_ready. An output fire is out_valid&&out_ready.
- Latency: a beat fired in cycle N is presented in cycle N+1 when the buffer is empty.
- Decode rules, with sign extension to XLEN from the MSB shown:
  - LOAD 0000011, MISC-MEM 0001111, JALR 1100111: fmt I, inst[31:20].
  - OP-IMM 0010011: fmt I, inst[31:20]. Exception: funct3 001/101 (shifts) gives zero-extended shamt, inst[24:20] for XLEN=32 and inst[25:20] for XLEN=64. funct7 bits are never part of inm.
  - STORE 0100011: fmt S, {inst[31:25],inst[11:7]}.
  - BRANCH 1100011: fmt B, {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - LUI 0110111, AUIPC 0010111: fmt U, {inst[31:12],12'b0}, sign-extended above bit 31 when XLEN=64.
  - JAL 1101111: fmt J, {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - SYSTEM 1110011 with funct3[2]=1: fmt Z, zero-extended inst[19:15]. With funct3[2]=0: fmt I.
  - OP 0110011: fmt R, inm 0.
  - Anything else, or inst[1:0]!=11: fmt 7, illegal=1, inm 0, target 0.
- target uses modulo 2^XLEN addition, wrap-around allowed. It equals pc+inm only for B, J and AUIPC.
- Skid buffer states:
  - EMPTY: out_valid=0, in_ready=1. Input fire goes to ONE.
  - ONE (main reg valid): in_ready=1.
    - Input fire with output fire: main is replaced, stay in ONE.
    - Input fire without output fire: beat goes to the skid reg, state TWO.
    - Output fire only: state EMPTY.
  - TWO: in_ready=0, in_valid ignored. Output fire moves skid to main, state ONE.
- in_ready is registered from state, with no combinational path from out_ready. Output order is always arrival order.
- out_valid and all out data are driven from the main reg only. Data must stay stable while out_valid&&!out_ready.
- flush: next state EMPTY and both regs invalidated. A beat offered in the flush cycle is dropped and not counted. ill_cnt is not cleared by flush.
- ill_cnt increments by 1 on each input fire with illegal decode. It holds at 2^ILL_CNT_W-1.
- Reset while RST_n is low: next edge gives state EMPTY, in_ready=0 (gated low while RST_n=0), out_valid=0, inm/fmt/illegal/target=0, ill_cnt=0. Reset mid-transfer discards all buffered beats.
- flush and reset together: reset wins.

Test Plan:
- ADDI 0xFFF00093, pc 0, out_ready=1 -> next cycle out_valid=1, inm=0xFFFFFFFF, fmt=1, illegal=0, target=0.
- BEQ 0xFE000EE3, pc 0x100 -> inm=0xFFFFFFFC, fmt=3, target=0x000000FC. JAL 0x001000EF, pc 0x1000 -> inm=0x800, fmt=5, target=0x1800.
- SRAI 0x4030D093 -> inm=3, fmt=1. CSRRWI 0x300FD073 -> inm=31, fmt=6. XLEN=64, LUI 0x800000B7 -> inm=0xFFFFFFFF80000000.
- out_ready=0 while driving 3 beats A,B,C -> A,B buffered; in_ready=0 from the cycle after B, so C is held by the source. Raise out_ready -> outputs A,B,C in order, no loss or duplication.
- inst 0x00000000 twice -> fmt=7, illegal=1, ill_cnt=2. With ILL_CNT_W=2, 5 illegal beats -> ill_cnt saturates at 3.
- State TWO, then flush with in_valid=1 -> out_valid=0 next cycle, flush-cycle beat dropped, ill_cnt unchanged. RST_n=0 for 1 cycle mid-stream -> all outputs 0, in_ready=0 during reset and 1 after.
